// File: rtl/cpu_boot_ctrl_if.sv
// Program-load stream and CPU memory write port of the boot controller.
// The controller side uses the slave modport, the loader/memory side uses master.
interface cpu_boot_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic              ld_valid;
   logic              ld_ready;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      output ld_valid, ld_data, ld_last,
      input  ld_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  ld_valid, ld_data, ld_last,
      output ld_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cpu_boot_ctrl.sv
// Loads a VeriRISC program into CPU memory, holds the CPU in reset, then runs it
// with a 4-bit phase counter until halt or a cycle timeout.
module cpu_boot_ctrl #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 8,
   parameter int RST_HOLD = 2,
   parameter int TIMEOUT  = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   cpu_boot_ctrl_if.slave    bus,
   output logic              cpu_rst,
   output logic [3:0]        count,
   output logic              control_clk,
   output logic              cpu_clk,
   output logic              fetch,
   output logic              alu_clk,
   input  logic              halt,
   output logic [ADDR_W:0]   words_loaded,
   output logic              done,
   output logic              timeout
);
   localparam int CYC_W  = $clog2(TIMEOUT) + 1;
   localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;
   localparam logic [ADDR_W:0]   LAST_SLOT = (ADDR_W+1)'((1 << ADDR_W) - 1);
   localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TIMEOUT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CRST,
      RUN,
      DONE,
      ERR
   } state_t;

   state_t            state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [CYC_W-1:0]  cyc_cnt;

   assign control_clk = ~count[0];
   assign cpu_clk     = count[1];
   assign fetch       = ~count[3];
   assign alu_clk     = ~(count == 4'hC);

   // words_loaded doubles as the write pointer; it is cleared on every start
   // and stops advancing once the last slot is taken, so it never wraps.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         count         <= 4'd0;
         words_loaded  <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.ld_ready  <= 1'b0;
         cpu_rst       <= 1'b0;
         done          <= 1'b0;
         timeout       <= 1'b0;
         hold_cnt      <= '0;
         cyc_cnt       <= '0;
      end else begin
         bus.mem_we <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state        <= LOAD;
                  bus.ld_ready <= 1'b1;
                  cpu_rst      <= 1'b0;
                  count        <= 4'd0;
                  words_loaded <= '0;
                  done         <= 1'b0;
                  timeout      <= 1'b0;
               end
            end
            LOAD: begin
               if (bus.ld_valid && bus.ld_ready) begin
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= words_loaded[ADDR_W-1:0];
                  bus.mem_wdata <= DATA_W'(bus.ld_data);
                  words_loaded  <= words_loaded + (ADDR_W+1)'(1);
                  if (bus.ld_last || (words_loaded == LAST_SLOT)) begin
                     state        <= CRST;
                     bus.ld_ready <= 1'b0;
                     hold_cnt     <= '0;
                  end
               end
            end
            CRST: begin
               if (hold_cnt == HOLD_LAST) begin
                  state   <= RUN;
                  cpu_rst <= 1'b1;
                  cyc_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            // Halt takes priority over a timeout landing on the same edge.
            RUN: begin
               count   <= count + 4'd1;
               cyc_cnt <= cyc_cnt + CYC_W'(1);
               if (halt) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (cyc_cnt == CYC_LAST) begin
                  state   <= ERR;
                  timeout <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
